// File: rtl/aes_core_arbiter.sv
// Round-robin sequencer sharing one AES-128 core among N_REQ requesters; one block in flight at a time.
// Optional WAIT watchdog is compiled in with AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_text,
  input  logic [N_REQ*DATA_W-1:0]   req_key,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      core_input_valid,
  output logic [DATA_W-1:0]         core_text,
  output logic [DATA_W-1:0]         core_key,
  input  logic                      core_valid_output,
  input  logic [DATA_W-1:0]         core_cipher,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  input  logic [N_REQ-1:0]          rsp_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  pick;
  logic              pick_vld;
  logic [DATA_W-1:0] result;
  logic              timeout_hit;

  // First valid requester after the previous winner, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!pick_vld && req_valid[(int'(last_grant) + k) % N_REQ]) begin
        pick     = IDX_W'((int'(last_grant) + k) % N_REQ);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err;

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES)) && !core_valid_output;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (state == WAIT) begin
      if (core_valid_output) begin
        err <= 1'b0;
      end else if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

  assign rsp_error = err;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign rsp_error          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready is gated by rst so an asserted reset silences it even with requests pending.
  always_comb begin
    state_nxt        = state;
    req_ready        = '0;
    core_input_valid = 1'b0;
    rsp_valid        = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          req_ready[pick] = rst;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        core_input_valid = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT: begin
        if (core_valid_output || timeout_hit) begin
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_ready[grant]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_text  <= '0;
      core_key   <= '0;
      grant      <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
    end else if (state == IDLE && pick_vld) begin
      core_text  <= req_text[int'(pick)*DATA_W +: DATA_W];
      core_key   <= req_key[int'(pick)*DATA_W +: DATA_W];
      grant      <= pick;
      last_grant <= pick;
    end
  end

  // A timeout abort returns an all-zero block rather than stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= '0;
    end else if (state == WAIT) begin
      if (core_valid_output) begin
        result <= core_cipher;
      end else if (timeout_hit) begin
        result <= '0;
      end
    end
  end

  assign rsp_data = result;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a stub AES core and a transaction-level reference model.
`timescale 1ns/1ps
module tb_aes_core_arbiter;

  localparam int N   = 4;
  localparam int W   = 128;
  localparam int TO  = 8;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_text, req_key;
  logic           core_input_valid, core_valid_output, rsp_error;
  logic [W-1:0]   core_text, core_key, core_cipher, rsp_data;

  int total = 0;
  int bad   = 0;

  aes_core_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_text(req_text), .req_key(req_key), .req_ready(req_ready),
    .core_input_valid(core_input_valid), .core_text(core_text), .core_key(core_key),
    .core_valid_output(core_valid_output), .core_cipher(core_cipher),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // Stub core transfer function: real AES answer for the FIPS-197 vector, a cheap mix otherwise.
  function automatic logic [W-1:0] cipher_fn(input logic [W-1:0] t, input logic [W-1:0] k);
    if (t == 128'h00112233445566778899aabbccddeeff && k == 128'h000102030405060708090a0b0c0d0e0f)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    return t ^ {k[63:0], k[127:64]} ^ {4{32'h5a5ac3c3}};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Stub AES core: completes stub_lat+1 cycles after the start pulse; stub_lat=0 never completes.
  int stub_lat = LAT;
  bit spur_en  = 1'b0;
  initial begin
    bit           started, spur;
    int           cnt;
    logic [W-1:0] st_t, st_k;
    cnt = 0; st_t = '0; st_k = '0;
    core_valid_output = 1'b0;
    core_cipher       = '0;
    forever begin
      @(negedge clk);
      started = rst && core_input_valid;
      spur    = rst && spur_en && |(req_valid & req_ready);
      @(posedge clk); #1;
      core_valid_output = 1'b0;
      if (!rst) begin
        cnt = 0;
      end else if (started) begin
        st_t = core_text; st_k = core_key; cnt = stub_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_valid_output = 1'b1;
          core_cipher       = cipher_fn(st_t, st_k);
        end
      end
      if (spur) begin
        core_valid_output = 1'b1;
        core_cipher       = '1;
      end
    end
  end

  // Reference model: one transaction at a time, tracked by age in cycles since its accept.
  bit           m_busy, m_rsp, m_err;
  int           m_age, m_grant, m_last;
  logic [W-1:0] m_text, m_key, m_data;
  always @(negedge clk) begin : model_blk
    int         g;
    logic [N-1:0] e_rdy, e_rv;
    if (!rst) begin
      m_busy = 0; m_rsp = 0; m_err = 0; m_age = 0; m_grant = 0; m_last = N - 1;
      m_text = '0; m_key = '0; m_data = '0;
      check("rst_req_ready", req_ready, '0);
      check("rst_core_input_valid", core_input_valid, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_error", rsp_error, '0);
      check("rst_core_text", core_text, '0);
      check("rst_core_key", core_key, '0);
      check("rst_rsp_data", rsp_data, '0);
    end else begin
      g     = m_busy ? -1 : rr_pick(req_valid, m_last);
      e_rdy = (g >= 0) ? (N'(1) << g) : N'(0);
      e_rv  = m_rsp ? (N'(1) << m_grant) : N'(0);
      check("req_ready", req_ready, e_rdy);
      check("core_input_valid", core_input_valid, (m_busy && !m_rsp && m_age == 1));
      check("rsp_valid", rsp_valid, e_rv);
      check("core_text", core_text, m_text);
      check("core_key", core_key, m_key);
      if (m_rsp) begin
        check("rsp_data", rsp_data, m_data);
        check("rsp_error", rsp_error, m_err);
      end
      if (g >= 0) begin
        m_busy = 1; m_age = 1; m_grant = g; m_last = g;
        m_text = req_text[g*W +: W];
        m_key  = req_key[g*W +: W];
      end else if (m_busy && !m_rsp) begin
        if (m_age >= 2 && core_valid_output) begin
          m_rsp = 1; m_err = 0; m_data = cipher_fn(m_text, m_key);
        end
`ifdef AES_ARB_TIMEOUT_EN
        else if (m_age - 2 == TO) begin
          m_rsp = 1; m_err = 1; m_data = '0;
        end
`endif
        m_age++;
      end else if (m_rsp && rsp_ready[m_grant]) begin
        m_busy = 0; m_rsp = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept(output int g);
    g = -1;
    for (int c = 0; c < 200 && g < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) g = i;
    end
    total++;
    if (g < 0) begin
      bad++;
      $display("FAIL accept_wait: no grant within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp(output int cyc, output logic [N-1:0] rv, output logic [W-1:0] rd, output logic re);
    cyc = 0; rv = '0; rd = '0; re = 1'b0;
    while (rv == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rv = rsp_valid; rd = rsp_data; re = rsp_error;
    end
    total++;
    if (rv == 0) begin
      bad++;
      $display("FAIL rsp_wait: no response within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           g, cyc;
    logic [N-1:0] rv;
    logic [W-1:0] rd;
    logic         re;
    req_valid = '0; req_text = '0; req_key = '0; rsp_ready = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    check("idle_no_ready", req_ready, '0);

    // FIPS-197 vector through requester 0
    req_text[0 +: W] = 128'h00112233445566778899aabbccddeeff;
    req_key[0 +: W]  = 128'h000102030405060708090a0b0c0d0e0f;
    req_valid = 4'b0001;
    wait_accept(g);
    check("fips_grant", g, 0);
    req_valid = '0;
    wait_rsp(cyc, rv, rd, re);
    check("fips_latency", cyc, LAT + 3);
    check("fips_rsp_valid", rv, 4'b0001);
    check("fips_rsp_data", rd, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("fips_rsp_error", re, 1'b0);
    rsp_ready = 4'b1110;
    tick(); tick();
    check("other_ready_ignored", rsp_valid, 4'b0001);
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;

    for (int i = 0; i < N; i++) begin
      req_text[i*W +: W] = {4{32'h11110000 + i}};
      req_key[i*W +: W]  = {4{32'hc0de0000 + i}};
    end

    // Reset asserted while WAITing on a slow core
    stub_lat  = 10;
    req_valid = 4'b0100;
    wait_accept(g);
    check("pre_reset_grant", g, 2);
    req_valid = '0;
    tick(); tick();
    req_valid = 4'b1111;
    #1 rst = 1'b0;
    #1;
    check("async_req_ready", req_ready, '0);
    check("async_core_input_valid", core_input_valid, '0);
    check("async_rsp_valid", rsp_valid, '0);
    check("async_core_text", core_text, '0);
    check("async_core_key", core_key, '0);
    check("async_rsp_data", rsp_data, '0);
    req_valid = '0;
    tick();
    rst      = 1'b1;
    stub_lat = LAT;
    tick();

    // All requesters valid, responses always accepted
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_accept(g);
      check("rr_order", g, n % N);
    end
    req_valid = '0;
    repeat (LAT + 6) tick();

    // Pointer behaviour with sparse requests
    req_valid = 4'b1000;
    wait_accept(g);
    check("sparse_grant3", g, 3);
    req_valid = 4'b0100;
    wait_accept(g);
    check("wrap_grant2", g, 2);
    req_valid = 4'b1010;
    wait_accept(g);
    check("ptr_grant3_first", g, 3);
    req_valid = 4'b0010;
    wait_accept(g);
    check("ptr_grant1_next", g, 1);
    req_valid = '0;
    repeat (LAT + 6) tick();

    // Spurious completion during ISSUE, then response held off for 20 cycles
    rsp_ready = '0;
    spur_en   = 1'b1;
    req_valid = 4'b0001;
    wait_accept(g);
    check("hold_grant", g, 0);
    spur_en   = 1'b0;
    req_valid = '0;
    wait_rsp(cyc, rv, rd, re);
    check("spur_latency", cyc, LAT + 3);
    check("spur_rsp_data", rd, cipher_fn({4{32'h11110000}}, {4{32'hc0de0000}}));
    req_valid = 4'b0100;
    for (int n = 0; n < 20; n++) begin
      if (n == 5) req_valid = '0;
      tick();
      check("hold_rsp_valid", rsp_valid, 4'b0001);
      check("hold_rsp_data", rsp_data, rd);
    end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = '0;
    repeat (4) tick();

`ifdef AES_ARB_TIMEOUT_EN
    // Core that never completes
    stub_lat  = 0;
    req_valid = 4'b0010;
    wait_accept(g);
    check("to_grant", g, 1);
    req_valid = '0;
    wait_rsp(cyc, rv, rd, re);
    check("to_latency", cyc, TO + 3);
    check("to_rsp_valid", rv, 4'b0010);
    check("to_rsp_data", rd, '0);
    check("to_rsp_error", re, 1'b1);
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = '0;
    stub_lat  = LAT;
    repeat (3) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
# aes_core_arbiter

Round-robin arbiter and sequencer that shares one AES-128 encryption core among N_REQ requesters. Accepts one plaintext/key pair at a time, launches the core with a single-cycle start pulse, and holds the core inputs stable for the whole encryption. Captures the ciphertext when the core signals completion and returns it to the granted requester over a valid/ready response handshake. Sits between the requester ports and the AES top level, directly driving the core's input_valid and consuming its valid_output.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- DATA_W, 128: block and key width.
- TIMEOUT_CYCLES, 63: maximum WAIT cycles before abort. Used only with AES_ARB_TIMEOUT_EN.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request
- req_text  in  N_REQ*DATA_W  plaintexts; requester i at bits [i*DATA_W +: DATA_W]
- req_key  in  N_REQ*DATA_W  keys, same packing
- req_ready  out  N_REQ  one-hot accept; a request transfers when req_valid[i] & req_ready[i]
- core_input_valid  out  1  start pulse to the AES core
- core_text  out  DATA_W  plaintext to the core
- core_key  out  DATA_W  key to the core
- core_valid_output  in  1  core completion
- core_cipher  in  DATA_W  core ciphertext, valid when core_valid_output=1
- rsp_valid  out  N_REQ  one-hot response valid, to the granted requester
- rsp_data  out  DATA_W  ciphertext
- rsp_error  out  1  response is a timeout abort
- rsp_ready  in  N_REQ  per-requester response accept

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle.
  - On that edge, latch req_text[g] and req_key[g] into core_text and core_key, register g, set last_grant=g, and go to ISSUE.
  - No req_valid set: stay in IDLE and assert no ready.
- ISSUE: core_input_valid=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - core_valid_output=1: capture core_cipher into the result register, set rsp_error=0, go to RESPOND.
  - Timeout (macro enabled): go to RESPOND with result=0 and rsp_error=1.
- RESPOND:
  - rsp_valid[g]=1 and rsp_data=result.
  - rsp_ready[g]=1 returns to IDLE.
  - rsp_ready from any other requester is ignored.
- core_text and core_key change only on an IDLE accept and are held stable through ISSUE, WAIT and RESPOND.
- core_valid_output outside WAIT is ignored, including a spurious pulse during ISSUE.
- Requests made while busy wait. req_ready is 0 in every state other than IDLE.
- A requester may drop req_valid before it is granted, with no effect.

## Timing
- Reset values:
  - FSM in IDLE.
  - req_ready=0, core_input_valid=0, rsp_valid=0, rsp_error=0.
  - core_text=0, core_key=0, rsp_data=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - Timeout counter=0.
- Reset mid-operation: immediate return to IDLE and the result is discarded. The core shares rst.
- Accept at IDLE cycle T, core_input_valid at T+1, WAIT from T+2.
- Core valid_output seen in WAIT at cycle C: rsp_valid is high from C+1 and is held until rsp_ready.
- Earliest next accept is the cycle after the rsp_ready handshake.
- Back-to-back issue overhead is 3 cycles plus the core latency.
- Fairness: with all requesters continuously valid, the grant order is 0,1,…,N_REQ-1,0.

## Configuration
- AES_ARB_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to WAIT and increments in every WAIT cycle.
  - If the counter equals TIMEOUT_CYCLES and core_valid_output=0, the block aborts to RESPOND with rsp_error=1 and rsp_data=0.
  - If core_valid_output=1 in the same cycle as the limit, completion wins.
- AES_ARB_TIMEOUT_EN undefined: no counter, WAIT is indefinite, and rsp_error is tied to 0.

## Test plan
- Single request, FIPS-197 vector: req 0 with key 000102…0f and text 00112233…ff. Expect rsp_valid[0] with rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a and rsp_error=0.
- All 4 requests held valid, rsp_ready tied to 1: grants are 0,1,2,3,0, and each req_ready is a single cycle.
- req 2 valid after serving 3: grant 2. Then reqs 1 and 3 valid: grant 3 first (pointer 2→3), then 1.
- rsp_ready held low 20 cycles: rsp_valid and rsp_data stay stable, no new accept, and core_input_valid stays 0.
- Assert rst in WAIT: all outputs return to reset values asynchronously, and the next request is serviced normally.
- AES_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and a stub core that never completes: rsp_valid rises 9 cycles after WAIT entry with rsp_error=1 and rsp_data=0.
